// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time / duty measurement with stuck-line timeout
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_TRIG = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_STUCK} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       per_cnt, hi_cnt;
  logic                   snap, ovr, stuck_trig, stuck_pend, stuck_req;

  logic                   div_busy;
  logic [3:0]             div_cnt;
  logic [CNT_W-1:0]       div_rem, div_den, div_hi, div_diff, div_rem_next;
  logic [6:0]             div_q;
  logic [CNT_W:0]         div_shift;
  logic                   div_ge, div_last, div_run;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_ONE;
      hi_cnt  <= CNT_ONE;
    end else begin
      if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
      if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Timeout fires on the cycle per_cnt steps onto its saturation value.
  always_comb begin
    state_next = state;
    snap       = 1'b0;
    ovr        = 1'b0;
    stuck_trig = 1'b0;
    case (state)
      S_IDLE:  if (rise) state_next = S_MEAS;
      S_MEAS: begin
        if (rise) begin
          if (div_busy) ovr  = 1'b1;
          else          snap = 1'b1;
        end else if (per_cnt == CNT_TRIG) begin
          stuck_trig = 1'b1;
          state_next = S_STUCK;
        end
      end
      S_STUCK: if (rise) state_next = S_MEAS;
      default: state_next = S_IDLE;
    endcase
  end

  // Restoring divide of {hi,8'b0} by per: hi < per, so the remainder starts as hi
  // and only the eight fractional quotient bits need to be produced.
  assign div_shift    = {div_rem, 1'b0};
  assign div_ge       = div_shift >= {1'b0, div_den};
  assign div_diff     = div_shift[CNT_W-1:0] - div_den;
  assign div_rem_next = div_ge ? div_diff : div_shift[CNT_W-1:0];
  assign div_last     = div_busy && (div_cnt == 4'd7);
  assign div_run      = div_busy && (div_cnt != 4'd8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_cnt  <= '0;
      div_rem  <= '0;
      div_den  <= '0;
      div_hi   <= '0;
      div_q    <= '0;
    end else if (snap) begin
      div_busy <= 1'b1;
      div_cnt  <= '0;
      div_rem  <= hi_cnt;
      div_den  <= per_cnt;
      div_hi   <= hi_cnt;
      div_q    <= '0;
    end else if (div_busy) begin
      div_cnt <= div_cnt + 4'd1;
      if (div_cnt == 4'd8) begin
        div_busy <= 1'b0;
      end else begin
        div_rem <= div_rem_next;
        div_q   <= {div_q[5:0], div_ge};
      end
    end
  end

  assign stuck_req = stuck_trig | stuck_pend;

  // A stuck report never shares a cycle with a division result; it waits for the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
      stuck_pend <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= ovr;
      if (div_last) begin
        period    <= div_den;
        high_time <= div_hi;
        duty      <= {div_q, div_ge};
        valid     <= 1'b1;
        stuck     <= 1'b0;
        if (stuck_trig) stuck_pend <= 1'b1;
      end else if (stuck_req && !div_run) begin
        period     <= '0;
        high_time  <= '0;
        duty       <= s ? 8'hFF : 8'h00;
        valid      <= 1'b1;
        stuck      <= 1'b1;
        stuck_pend <= 1'b0;
      end else if (stuck_trig) begin
        stuck_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;
  localparam int CNT_W = 12;
  localparam int SYNC  = 2;
  localparam int TMO   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [7:0]       duty;
  logic             valid, stuck, overrun;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .duty(duty), .valid(valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int h; int d; int st; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int have_prev = 0, last_p = 0, last_h = 0, last_d = 0;
  int last_acc = -1000, last_rise = 0, exp_ovr = 0, ovr_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (overrun) ovr_seen++;
    if (valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("period", int'(period), e.p);
        check("high_time", int'(high_time), e.h);
        check("duty", int'(duty), e.d);
        check("stuck", int'(stuck), e.st);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a rising edge; the previous period is reported unless the divider is still busy.
  task automatic start_rise();
    exp_t x;
    pwm_in = 1'b1;
    last_rise = cyc;
    if (have_prev != 0) begin
      if (cyc - last_acc >= 10) begin
        x = '{p: last_p, h: last_h, d: last_d, st: 0, cyc: cyc + SYNC + 9};
        sb.push_back(x);
        last_acc = cyc;
      end else begin
        exp_ovr++;
      end
    end
  endtask

  task automatic do_period(input int p, input int h, input int d);
    start_rise();
    wait_clk(h);
    pwm_in = 1'b0;
    wait_clk(p - h);
    have_prev = 1;
    last_p = p;
    last_h = h;
    last_d = d;
  endtask

  task automatic push_stuck(input int d);
    exp_t x;
    x = '{p: 0, h: 0, d: d, st: 1, cyc: last_rise + SYNC + TMO};
    sb.push_back(x);
    have_prev = 0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    wait_clk(1);
  endtask

  initial begin
    wait_clk(1);
    for (int i = 0; i < 24; i++) begin
      pwm_in = i[1];
      wait_clk(1);
    end
    check_zero("reset");
    pwm_in = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(5);

    repeat (3) do_period(540, 108, 51);
    do_period(540, 432, 204);
    do_period(540, 1, 0);
    do_period(540, 539, 255);
    do_period(540, 108, 51);

    repeat (6) do_period(6, 3, 128);
    repeat (2) do_period(540, 108, 51);

    start_rise();
    push_stuck(255);
    wait_clk(TMO + 200);

    pwm_in = 1'b0;
    wait_clk(4);
    do_period(540, 108, 51);
    push_stuck(0);
    wait_clk(TMO);

    repeat (3) do_period(540, 432, 204);

    start_rise();
    wait_clk(SYNC + 4);
    reset = 1'b1;
    wait_clk(2);
    pwm_in = 1'b0;
    wait_clk(3);
    check_zero("mid_reset");
    sb.delete();
    reset = 1'b0;
    have_prev = 0;
    last_acc = -1000;
    wait_clk(20);
    check_zero("post_reset");

    repeat (3) do_period(540, 108, 51);
    wait_clk(30);

    check("scoreboard_drained", sb.size(), 0);
    check("overrun_count", ovr_seen, exp_ovr);
    check("overrun_expected", exp_ovr, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
